mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/arbiter_pkg.sv | 24 ++
 rtl/rr_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arbiter_pkg                                                        |
// | Shared types and constants for the memory arbiter.                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam int c_num_req   = 4;
    localparam int c_max_burst = 16;

    localparam int REQ_PE   = 0;
    localparam int REQ_SA3  = 1;
    localparam int REQ_SA2  = 2;
    localparam int REQ_DISP = 3;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pick                                                            |
// | Round-robin winner select: first eligible index at or above ptr.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rr_pick
    import arbiter_pkg::*;
#(
    parameter int NUM_REQ = c_num_req,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    always_comb begin
        int            w_k;
        logic [IW-1:0] w_idx;
        winner = '0;
        valid  = 1'b0;
        w_k    = 0;
        w_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k   = (int'(ptr) + i) % NUM_REQ;
            w_idx = w_k[IW-1:0];
            if (!valid && eligible[w_idx]) begin
                winner[w_idx] = 1'b1;
                valid         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arbiter                                                        |
// | Round-robin memory arbiter with burst limit and one-cycle release. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_arbiter
    import arbiter_pkg::*;
#(
    parameter int NUM_REQ   = c_num_req,
    parameter int MAX_BURST = c_max_burst,
    parameter int IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int BW        = $clog2(MAX_BURST + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] en,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      owner,
    output logic               busy,
    output logic [BW-1:0]      burst_cnt,
    output logic               timeout
);

    localparam logic [BW-1:0] c_burst_last = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0] c_last_idx   = IW'(NUM_REQ - 1);

    arb_state_t         r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [IW-1:0]      r_owner, w_owner_nxt;
    logic [BW-1:0]      r_cnt, w_cnt_nxt;
    logic               r_timeout, w_timeout_nxt;
    logic [IW-1:0]      r_ptr, w_ptr_nxt;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_win;
    logic               w_valid;
    logic [IW-1:0]      w_win_idx;
    logic               w_cap;
    logic               w_stop;

    assign w_elig = req & en;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .eligible (w_elig),
        .ptr      (r_ptr),
        .winner   (w_win),
        .valid    (w_valid)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win[i]) w_win_idx = IW'(i);
        end
    end

    // Only the owner's bits matter; everyone else is ignored mid-grant.
    assign w_cap  = (r_cnt == c_burst_last);
    assign w_stop = done[r_owner] | ~req[r_owner] | ~en[r_owner];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_ptr     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_owner   <= w_owner_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
            r_ptr     <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_owner_nxt   = r_owner;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        w_ptr_nxt     = r_ptr;
        case (r_state)
            ST_GRANT: begin
                if (w_cap || w_stop) begin
                    w_state_nxt   = ST_RELEASE;
                    w_gnt_nxt     = '0;
                    w_owner_nxt   = '0;
                    w_cnt_nxt     = '0;
                    // A coincident done/drop counts as a normal release.
                    w_timeout_nxt = w_cap & ~w_stop;
                    w_ptr_nxt     = (r_owner == c_last_idx) ? '0 : r_owner + 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt = '0;
                if (w_valid) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = w_win;
                    w_owner_nxt = w_win_idx;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_owner_nxt = '0;
                end
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign owner     = r_owner;
    assign busy      = |r_gnt;
    assign burst_cnt = r_cnt;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_arbiter                                                     |
// | Directed and random stimulus against a behavioural arbiter model.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mem_arbiter;
    import arbiter_pkg::*;

    localparam int N  = 4;
    localparam int MB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, en, done;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic [4:0] burst_cnt;
    logic       timeout;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_REQ   (N),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .en        (en),
        .done      (done),
        .gnt       (gnt),
        .owner     (owner),
        .busy      (busy),
        .burst_cnt (burst_cnt),
        .timeout   (timeout)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: owner index (-1 = nobody), cycles into grant, rr pointer, timeout pulse.
    int m_owner, m_cnt, m_ptr;
    bit m_to;
    int q_order[$];

    function automatic bit bt(input logic [3:0] v, input int i);
        return v[i[1:0]] === 1'b1;
    endfunction

    function automatic void m_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void m_step(input logic [3:0] r, input logic [3:0] e, input logic [3:0] d);
        bit cap;
        bit oth;
        int k;
        if (m_owner >= 0) begin
            cap = (m_cnt == MB - 1);
            oth = bt(d, m_owner) || !bt(r, m_owner) || !bt(e, m_owner);
            if (cap || oth) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_cnt   = 0;
                m_to    = cap && !oth;
            end else begin
                m_cnt++;
                m_to = 1'b0;
            end
        end else begin
            m_to  = 1'b0;
            m_cnt = 0;
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (m_owner < 0 && bt(r, k) && bt(e, k)) begin
                    m_owner = k;
                    q_order.push_back(k);
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("gnt",       32'(gnt),       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("owner",     32'(owner),     (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("busy",      32'(busy),      32'(m_owner >= 0));
        chk("burst_cnt", 32'(burst_cnt), 32'(m_cnt));
        chk("timeout",   32'(timeout),   32'(m_to));
    endtask

    task automatic cycle(input logic [3:0] r, input logic [3:0] e, input logic [3:0] d);
        @(negedge clk);
        check_all();
        req  = r;
        en   = e;
        done = d;
        m_step(r, e, d);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_cmp++;
            assert ($onehot0(gnt) && (busy === |gnt)) else begin
                n_err++;
                $error("FAIL onehot_busy: gnt=%b busy=%b required onehot0 gnt and busy=|gnt", gnt, busy);
            end
        end
    end

    initial begin
        int n_to;
        int max_cnt;
        logic [3:0] d;

        rst_n = 1'b0;
        req   = '0;
        en    = '0;
        done  = '0;
        m_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Two requesters finishing after three cycles alternate.
        q_order.delete();
        for (int t = 0; t < 18; t++) begin
            d = (m_owner >= 0 && m_cnt == 2) ? 4'(1 << m_owner) : 4'b0;
            cycle(4'b0110, 4'b1111, d);
        end
        chk("order_len", 32'(q_order.size() >= 4), 32'd1);
        chk("order0", 32'(q_order[0]), 32'd1);
        chk("order1", 32'(q_order[1]), 32'd2);
        chk("order2", 32'(q_order[2]), 32'd1);
        chk("order3", 32'(q_order[3]), 32'd2);
        repeat (2) cycle(4'b0000, 4'b0000, 4'b0000);

        // Single requester hitting the burst limit.
        n_to    = 0;
        max_cnt = 0;
        for (int t = 0; t < 20; t++) begin
            cycle(4'b0001, 4'b1111, 4'b0000);
            if (timeout === 1'b1) n_to++;
            if (32'(burst_cnt) > max_cnt) max_cnt = 32'(burst_cnt);
        end
        chk("timeout_count", 32'(n_to), 32'd1);
        chk("burst_max", 32'(max_cnt), 32'(MB - 1));
        repeat (2) cycle(4'b0000, 4'b0000, 4'b0000);

        // Enable mask: only 1 and 3 may be granted, and they alternate.
        q_order.delete();
        for (int t = 0; t < 12; t++) begin
            d = (m_owner >= 0 && m_cnt == 1) ? 4'(1 << m_owner) : 4'b0;
            cycle(4'b1111, 4'b1010, d);
        end
        for (int i = 0; i < q_order.size(); i++) begin
            chk("en_mask_idx", 32'(q_order[i] == 1 || q_order[i] == 3), 32'd1);
            if (i > 0) chk("en_mask_alt", 32'(q_order[i] != q_order[i-1]), 32'd1);
        end
        for (int t = 0; t < 40 && !(m_owner == 3 && m_cnt == 2); t++)
            cycle(4'b1111, 4'b1010, 4'b0000);
        chk("wait_owner3", 32'(m_owner == 3 && m_cnt == 2), 32'd1);
        cycle(4'b1111, 4'b0010, 4'b0000);
        cycle(4'b1111, 4'b0010, 4'b0000);
        chk("en_drop_gnt", 32'(gnt), 32'd0);
        repeat (2) cycle(4'b0000, 4'b0000, 4'b0000);

        // done coinciding with the burst limit is a plain release.
        n_to = 0;
        for (int t = 0; t < 20; t++) begin
            d = (m_owner == 0 && m_cnt == MB - 1) ? 4'b0001 : 4'b0000;
            cycle(4'b0001, 4'b1111, d);
            if (timeout === 1'b1) n_to++;
        end
        chk("coincide_timeout", 32'(n_to), 32'd0);
        repeat (2) cycle(4'b0000, 4'b0000, 4'b0000);

        // Asynchronous reset mid-grant.
        for (int t = 0; t < 20 && !(m_owner == 0 && m_cnt == 7); t++)
            cycle(4'b0001, 4'b1111, 4'b0000);
        chk("wait_cnt7", 32'(m_owner == 0 && m_cnt == 7), 32'd1);
        @(negedge clk);
        check_all();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt",     32'(gnt),       32'd0);
        chk("rst_owner",   32'(owner),     32'd0);
        chk("rst_busy",    32'(busy),      32'd0);
        chk("rst_cnt",     32'(burst_cnt), 32'd0);
        chk("rst_timeout", 32'(timeout),   32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1000;
        en    = 4'b1111;
        done  = 4'b0000;
        m_step(req, en, done);
        cycle(4'b1000, 4'b1111, 4'b0000);
        chk("post_rst_gnt",   32'(gnt),   32'd8);
        chk("post_rst_owner", 32'(owner), 32'(REQ_DISP));
        repeat (2) cycle(4'b0000, 4'b0000, 4'b0000);

        // Random traffic.
        for (int t = 0; t < 400; t++) begin
            logic [3:0] r, e;
            r = 4'($urandom);
            e = 4'($urandom) | 4'($urandom);
            d = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            cycle(r, e, d);
        end

        @(negedge clk);
        check_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
